// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, reads imem over req/ack and queues {pc, instr} for decode.
// Define FETCH_BYPASS_EN to present an acked word on if_* in the same cycle when the queue is empty.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [31:0]     pc, pc_n, addr_n;
  logic            req_n;
  logic [CW-1:0]   count, count_n;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [31:0]     mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic            fifo_valid, ack_v, push, pop, take;

  // Handshake: imem_req/imem_addr are registered and held until the cycle imem_ack=1;
  // that cycle completes the transfer, imem_ack without imem_req is ignored.
  assign ack_v      = imem_req & imem_ack;
  assign fifo_valid = (count != '0);
  assign dbg_state  = (state == DISCARD);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass = ack_v & (state == FETCH) & ~redirect & ~fifo_valid;
  assign take   = bypass & ~stall;

  always_comb begin
    if_valid = fifo_valid | bypass;
    if_instr = 32'h0;
    if_pc    = 32'h0;
    if (fifo_valid) begin
      if_instr = mem_instr[rd_ptr];
      if_pc    = mem_pc[rd_ptr];
    end else if (bypass) begin
      if_instr = imem_rdata;
      if_pc    = pc;
    end
  end
`else
  assign take = 1'b0;

  always_comb begin
    if_valid = fifo_valid;
    if_instr = 32'h0;
    if_pc    = 32'h0;
    if (fifo_valid) begin
      if_instr = mem_instr[rd_ptr];
      if_pc    = mem_pc[rd_ptr];
    end
  end
`endif

  assign if_pc_plus4 = if_valid ? (if_pc + 32'd4) : 32'h0;

  assign pop  = fifo_valid & ~stall & ~redirect;
  assign push = ack_v & (state == FETCH) & ~redirect & ~take;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    count_n = count;
    if (redirect) begin
      count_n = '0;
      pc_n    = redirect_pc & 32'hFFFF_FFFC;
      // A request still in flight must be drained before refetching.
      state_n = (imem_req & ~imem_ack) ? DISCARD : FETCH;
    end else begin
      if (state == DISCARD) begin
        if (ack_v) state_n = FETCH;
      end else if (ack_v) begin
        pc_n = pc + 32'd4;
      end
      count_n = count + CW'(push) - CW'(pop);
    end
    req_n  = (state_n == DISCARD) | (count_n < FULL);
    addr_n = (state_n == DISCARD) ? imem_addr : pc_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      count     <= count_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios then random traffic against a queue-based model.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: pending fetch PC, in-flight request view, stale-response flag, queue of {pc, instr}.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc, m_addr;
  logic        m_req, m_disc;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .dbg_state   (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc   = RESET_PC;
    m_addr = 32'h0;
    m_req  = 1'b0;
    m_disc = 1'b0;
  endtask

  task automatic model_clock(input logic a, input logic [31:0] d, input logic r,
                             input logic [31:0] rp, input logic s);
    logic ackv;
    ackv = m_req && a;
    if (r) begin
      exp_q.delete();
      m_disc = m_req && !a;
      m_pc   = rp & 32'hFFFF_FFFC;
    end else begin
      if (exp_q.size() > 0 && !s) void'(exp_q.pop_front());
      if (ackv) begin
        if (m_disc) m_disc = 1'b0;
        else begin
          exp_q.push_back({m_pc, d});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    m_req = m_disc || (exp_q.size() < DEPTH);
    if (!m_disc) m_addr = m_pc;
  endtask

  task automatic check_all(input string ph);
    logic        e_v;
    logic [31:0] e_instr, e_pc;
    e_v     = exp_q.size() > 0;
    e_instr = e_v ? exp_q[0][31:0]  : 32'h0;
    e_pc    = e_v ? exp_q[0][63:32] : 32'h0;
    chk({ph, "_req"},   32'(imem_req), 32'(m_req));
    chk({ph, "_addr"},  imem_addr, m_addr);
    chk({ph, "_valid"}, 32'(if_valid), 32'(e_v));
    chk({ph, "_instr"}, if_instr, e_instr);
    chk({ph, "_pc"},    if_pc, e_pc);
    chk({ph, "_pc4"},   if_pc_plus4, e_v ? e_pc + 32'd4 : 32'h0);
  endtask

  task automatic step(input string ph, input logic a, input logic [31:0] d, input logic r,
                      input logic [31:0] rp, input logic s);
    imem_ack    = a;
    imem_rdata  = d;
    redirect    = r;
    redirect_pc = rp;
    stall       = s;
    @(posedge clock);
    model_clock(a, d, r, rp, s);
    @(negedge clock);
    check_all(ph);
  endtask

  initial begin
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    model_reset();
    #12;
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc",    if_pc, 32'h0);
    chk("rst_pc4",   if_pc_plus4, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    check_all("rel");

    // First fetch and one-cycle latency
    step("t1_idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("t1_addr", imem_addr, 32'h0);
    step("t1_ack", 1'b1, 32'h8C01_0001, 1'b0, 32'h0, 1'b1);
    chk("t1_valid", 32'(if_valid), 32'h1);
    chk("t1_instr", if_instr, 32'h8C01_0001);
    chk("t1_pc",    if_pc, 32'h0);
    chk("t1_pc4",   if_pc_plus4, 32'h4);

    // Fill under stall, then drain in order
    repeat (5) step("t2_fill", 1'b1, $urandom, 1'b0, 32'h0, 1'b1);
    chk("t2_full_req", 32'(imem_req), 32'h0);
    chk("t2_head_pc",  if_pc, 32'h0);
    step("t2_pop", 1'b1, $urandom, 1'b0, 32'h0, 1'b0);
    chk("t2_resume_req",  32'(imem_req), 32'h1);
    chk("t2_resume_addr", imem_addr, 32'h10);
    repeat (3) step("t2_drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Redirect with no request outstanding
    repeat (5) step("t3_fill", 1'b1, $urandom, 1'b0, 32'h0, 1'b1);
    step("t3_redir", 1'b0, 32'h0, 1'b1, 32'h0000_3FFF, 1'b1);
    chk("t3_valid", 32'(if_valid), 32'h0);
    chk("t3_addr",  imem_addr, 32'h3FFC);
    chk("t3_req",   32'(imem_req), 32'h1);

    // Redirect while the request to 0x8 is outstanding
    step("t4_redir0", 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    step("t4_drop0",  1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b1);
    step("t4_f0",     1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b1);
    step("t4_f4",     1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b1);
    chk("t4_pend_addr", imem_addr, 32'h8);
    step("t4_redir", 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    chk("t4_disc_addr",  imem_addr, 32'h8);
    chk("t4_disc_state", 32'(dbg_state), 32'h1);
    step("t4_wait", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step("t4_ack",  1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    chk("t4_dropped", 32'(if_valid), 32'h0);
    chk("t4_addr",    imem_addr, 32'h100);
    chk("t4_state",   32'(dbg_state), 32'h0);

    // Redirect and ack in the same cycle
    step("t5_both", 1'b1, 32'hCAFE_F00D, 1'b1, 32'h200, 1'b1);
    chk("t5_valid", 32'(if_valid), 32'h0);
    chk("t5_addr",  imem_addr, 32'h200);
    chk("t5_state", 32'(dbg_state), 32'h0);

    // Reset with two entries queued and a request outstanding
    step("t6_f0", 1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b1);
    step("t6_f1", 1'b1, 32'hA000_0001, 1'b0, 32'h0, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_req",   32'(imem_req), 32'h0);
    chk("t6_valid", 32'(if_valid), 32'h0);
    chk("t6_instr", if_instr, 32'h0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    check_all("t6_rel");
    step("t6_idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("t6_addr", imem_addr, RESET_PC);

    // PC wrap-around
    step("wr_redir", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFA, 1'b1);
    step("wr_drop",  1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
    step("wr_f8",    1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
    step("wr_fc",    1'b1, 32'h9ABC_DEF0, 1'b0, 32'h0, 1'b1);
    step("wr_pop",   1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("wr_pc",   if_pc, 32'hFFFF_FFFC);
    chk("wr_pc4",  if_pc_plus4, 32'h0);
    chk("wr_addr", imem_addr, 32'h0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      logic        a, r, s;
      logic [31:0] rp;
      a  = ($urandom_range(99) < 60);
      s  = ($urandom_range(99) < 30);
      r  = ($urandom_range(99) < 8);
      rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      step("rnd", a, $urandom, r, rp, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
